// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronised line, single-clock oversample tick, start-bit validation,
// LSB-first byte assembly and valid/ready hand-off. Optional parity via UART_RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 27,
    parameter int OSR         = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 inp_clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     div_in,
    input  logic                 div_load,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    // state  | meaning
    // IDLE   | waiting for a falling edge on the synchronised line
    // START  | timing to the middle of the start bit, rejects glitches
    // DATA   | sampling DATA_BITS data bits at bit centres
    // PARITY | sampling the parity bit (parity build only)
    // STOP   | sampling the stop bit, then hand-off or frame error
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam int OS_W = $clog2(OSR);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    state_t               state;
    logic                 rx_m, rx_s, rx_p;
    logic [DIV_W-1:0]     div_reg, pend_div, tick_cnt;
    logic                 pend_valid;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

    // Counter is parked at 1 in IDLE so the first tick lands div_reg cycles after the edge.
    assign tick = (state != IDLE) && (tick_cnt == div_reg);

    always_ff @(posedge inp_clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_p       <= 1'b1;
            div_reg    <= DIV_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            tick_cnt   <= DIV_W'(1);
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            rx_p <= rx_s;

            // A divisor change never disturbs a frame in flight.
            if (div_load) begin
                if (state == IDLE) begin
                    div_reg    <= clamp_div(div_in);
                    pend_valid <= 1'b0;
                end else begin
                    pend_div   <= clamp_div(div_in);
                    pend_valid <= 1'b1;
                end
            end else if (state == IDLE && pend_valid) begin
                div_reg    <= pend_div;
                pend_valid <= 1'b0;
            end

            if (state == IDLE || tick) tick_cnt <= DIV_W'(1);
            else                       tick_cnt <= tick_cnt + DIV_W'(1);

            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (data_ready) data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_p && !rx_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt == OS_HALF) begin
                            os_cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            shift   <= {rx_s, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BC_W'(1);
                            if (bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            par_bad <= ((^shift) ^ rx_s) != parity_odd;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
                            state  <= IDLE;
                            busy   <= 1'b0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else if (!data_valid || data_ready) begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame-level reference model (latency formula,
// valid/ready/overrun rules) compared every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 27;
    localparam int OSR         = 16;
    localparam int DATA_BITS   = 8;
    localparam int FRAME_TICKS = OSR / 2 + OSR * DATA_BITS + OSR;

    logic             inp_clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             rx_in = 1'b1;
    logic [7:0]       data_out;
    logic             data_valid;
    logic             data_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;
    logic             man_ready = 1'b1;
    logic             rand_ready = 1'b1;
    logic             rand_mode = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic             parity_odd = 1'b0;
    logic             parity_err;
`endif

    assign data_ready = rand_mode ? rand_ready : man_ready;

    uart_rx_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .OSR(OSR), .DATA_BITS(DATA_BITS)) dut (
        .inp_clk(inp_clk), .rst(rst), .div_in(div_in), .div_load(div_load), .rx_in(rx_in),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd), .parity_err(parity_err),
`endif
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 inp_clk = ~inp_clk;

    int cyc = 0;
    always @(posedge inp_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: one pending frame outcome and one busy window at a time.
    int         ev_cycle = -1;
    int         ev_kind = 0;      // 0 none, 1 byte complete, 2 frame error
    logic [7:0] ev_byte = '0;
    int         bs = 0;
    int         be = -1;
    int         last_start = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = '0;
    logic       exp_ferr, exp_ov, exp_busy;
    logic       prev_ready = 1'b0;

    int         valid_rises = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = '0;
    int         ferr_cnt = 0;
    int         ov_cnt = 0;
    logic       dv_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge inp_clk);
            if (rst) begin
                exp_valid = 1'b0;
                ev_kind   = 0;
                bs        = 0;
                be        = -1;
                dv_d      = 1'b0;
                check("rst_data_out", 32'(data_out), 32'h0);
                check("rst_data_valid", 32'(data_valid), 32'h0);
                check("rst_frame_err", 32'(frame_err), 32'h0);
                check("rst_overrun", 32'(overrun), 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
                prev_ready = data_ready;
            end else begin
                exp_ferr = 1'b0;
                exp_ov   = 1'b0;
                if (ev_kind != 0 && cyc == ev_cycle) begin
                    if (ev_kind == 2) exp_ferr = 1'b1;
                    else if (!exp_valid || prev_ready) begin
                        exp_valid = 1'b1;
                        exp_data  = ev_byte;
                    end else exp_ov = 1'b1;
                end else if (exp_valid && prev_ready) begin
                    exp_valid = 1'b0;
                end
                prev_ready = data_ready;
                exp_busy = (cyc >= bs) && (cyc <= be);
                check("data_valid", 32'(data_valid), 32'(exp_valid));
                check("frame_err", 32'(frame_err), 32'(exp_ferr));
                check("overrun", 32'(overrun), 32'(exp_ov));
                check("busy", 32'(busy), 32'(exp_busy));
                if (exp_valid) check("data_out", 32'(data_out), 32'(exp_data));
                if (data_valid && !dv_d) begin
                    valid_rises++;
                    rise_cyc  = cyc;
                    rise_data = data_out;
                end
                dv_d = data_valid;
                if (frame_err) ferr_cnt++;
                if (overrun) ov_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge inp_clk);
            #1;
            if (rand_mode) rand_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge inp_clk);
        #1;
    endtask

    task automatic load_div(input int v);
        @(posedge inp_clk); #1;
        div_in   = DIV_W'(v);
        div_load = 1'b1;
        @(posedge inp_clk); #1;
        div_load = 1'b0;
    endtask

    // Sends start + data + stop; abort_bit >= 0 stops half-way through that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div,
                              input int low_after, input int gap, input int abort_bit);
        int bitc;
        bitc = OSR * div;
        @(posedge inp_clk); #1;
        last_start = cyc;
        ev_byte  = b;
        ev_kind  = stop ? 1 : 2;
        ev_cycle = cyc + 3 + FRAME_TICKS * div;
        bs = cyc + 3;
        be = ev_cycle - 1;
        hold(1'b0, bitc);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i == abort_bit) begin
                hold(b[i], bitc / 2);
                return;
            end
            hold(b[i], bitc);
        end
        hold(stop, bitc);
        if (!stop) hold(1'b0, low_after);
        hold(1'b1, gap);
    endtask

    task automatic false_start(input int len, input int div, input int gap);
        @(posedge inp_clk); #1;
        ev_kind = 0;
        bs = cyc + 3;
        be = cyc + 2 + (OSR / 2) * div;
        hold(1'b0, len);
        hold(1'b1, gap);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         rd;
        repeat (3) @(posedge inp_clk);
        #1;
        rst = 1'b0;

        load_div(4);
        send_frame(8'hA5, 1'b1, 4, 0, 40, -1);
        check("a5_data", 32'(rise_data), 32'hA5);
        check("a5_rises", 32'(valid_rises), 32'd1);
        check("a5_latency", 32'(rise_cyc - last_start), 32'd611);
        check("a5_valid_cleared", 32'(data_valid), 32'h0);

        false_start(20, 4, 60);
        check("glitch_no_valid", 32'(valid_rises), 32'd1);
        check("glitch_idle", 32'(busy), 32'h0);

        send_frame(8'h3C, 1'b0, 4, 200, 60, -1);
        check("ferr_pulses", 32'(ferr_cnt), 32'd1);
        check("ferr_no_valid", 32'(valid_rises), 32'd1);
        check("ferr_no_retrigger", 32'(busy), 32'h0);

        man_ready = 1'b0;
        send_frame(8'h11, 1'b1, 4, 0, 40, -1);
        send_frame(8'h22, 1'b1, 4, 0, 40, -1);
        check("ovr_data_kept", 32'(data_out), 32'h11);
        check("ovr_valid_held", 32'(data_valid), 32'h1);
        check("ovr_pulses", 32'(ov_cnt), 32'd1);
        man_ready = 1'b1;
        repeat (3) @(posedge inp_clk);
        #1;
        check("ovr_valid_cleared", 32'(data_valid), 32'h0);

        fork
            send_frame(8'h96, 1'b1, 4, 0, 40, -1);
            begin
                repeat (300) @(posedge inp_clk);
                #1;
                div_in   = DIV_W'(8);
                div_load = 1'b1;
                @(posedge inp_clk); #1;
                div_load = 1'b0;
            end
        join
        check("midload_old_div_data", 32'(rise_data), 32'h96);
        check("midload_old_div_latency", 32'(rise_cyc - last_start), 32'd611);
        send_frame(8'h69, 1'b1, 8, 0, 40, -1);
        check("newdiv_data", 32'(rise_data), 32'h69);
        check("newdiv_latency", 32'(rise_cyc - last_start), 32'd1219);
        load_div(1);
        send_frame(8'hF0, 1'b1, 2, 0, 40, -1);
        check("clamp_data", 32'(rise_data), 32'hF0);
        check("clamp_latency", 32'(rise_cyc - last_start), 32'd307);

        load_div(4);
        fork
            send_frame(8'h77, 1'b1, 4, 0, 0, 4);
            begin
                repeat (100) @(posedge inp_clk);
                #1;
                div_in   = DIV_W'(8);
                div_load = 1'b1;
                @(posedge inp_clk); #1;
                div_load = 1'b0;
            end
        join
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge inp_clk);
        #1;
        check("rstmid_data_out", 32'(data_out), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        send_frame(8'h5A, 1'b1, DEFAULT_DIV, 0, 40, -1);
        check("post_rst_data", 32'(rise_data), 32'h5A);
        check("post_rst_default_div", 32'(rise_cyc - last_start), 32'd4107);

        rand_mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd = int'($urandom_range(2, 5));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            load_div(rd);
            send_frame(rb, rs, rd, int'($urandom_range(0, 30)), int'($urandom_range(5, 30)), -1);
        end
        rand_mode = 1'b0;
        man_ready = 1'b1;
        repeat (5) @(posedge inp_clk);
        #1;
        check("final_valid_drained", 32'(data_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive sequencer: owns a programmable oversample-tick divider, detects the start bit, schedules mid-bit sampling, assembles the byte LSB-first and hands it off with a valid/ready handshake.
- Sits between the pad-side serial line and the receiver's byte consumer.
- Replaces free-running baud clocks with a single-clock tick enable, so no derived clocks exist in the receiver.

Parameters:
- DIV_W, 16, width of the divisor register and tick counter.
- DEFAULT_DIV, 27, reset divisor: input-clock cycles per oversample tick (50 MHz / (115200*16)).
- OSR, 16, oversample ticks per bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- inp_clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- div_in  input  DIV_W  new divisor value.
- div_load  input  1  one-cycle strobe to load div_in.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  received byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_out this cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a byte is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, div_reg=DEFAULT_DIV, state=IDLE, tick counter=1, rx synchroniser flops=1.
- Synchroniser: rx_in passes through a 2-flop synchroniser (rx_s); a third flop holds the previous value for edge detection.
- Divisor:
  - div_load in IDLE: div_reg <= div_in next cycle; values < 2 are clamped to 2.
  - div_load outside IDLE: value captured as pending and applied on the first IDLE cycle. A later load overwrites the pending value.
- Tick generator:
  - Counter runs 1..div_reg; tick=1 for one cycle when count==div_reg, then count <= 1.
  - In IDLE the counter is held at 1, so tick phase aligns to the start edge.
- State machine:
  - IDLE: on falling edge of rx_s (prev 1, now 0) -> START with os_cnt=0 and bit_cnt=0.
  - START: os_cnt increments on each tick. At the tick where os_cnt==OSR/2-1, sample rx_s:
    - 1 -> false start, back to IDLE, no outputs.
    - 0 -> DATA, os_cnt=0.
  - DATA: at the tick where os_cnt==OSR-1, sample rx_s into shift register bit position bit_cnt (LSB first) and clear os_cnt. After DATA_BITS samples -> STOP.
  - STOP: at the tick where os_cnt==OSR-1, sample rx_s and go to IDLE.
    - Sample 1: byte complete.
    - Sample 0: frame_err pulses the next cycle; the byte is discarded.
  - A line held low after a frame error does not retrigger; IDLE requires a falling edge.
- Handshake:
  - On byte complete, data_out and data_valid update the cycle after the stop-sample tick.
  - data_valid stays high, and data_out stays stable, until a cycle with data_ready=1; data_valid then clears next cycle.
  - Byte complete while data_valid=1 and data_ready=0: new byte dropped, old byte kept, overrun pulses one cycle.
  - Byte complete in the same cycle as data_ready=1: new byte loaded, data_valid stays 1, no overrun.
- Timing: total latency from the start-edge synchroniser output to data_valid is (OSR/2 + OSR*DATA_BITS + OSR) ticks + 1 cycle.
- Reset mid-frame: all state returns to reset values asynchronously; the partial byte is lost and any pending divisor is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at os_cnt==OSR-1.
  - Adds input parity_odd (1 bit, 1=odd parity) and output parity_err (one-cycle pulse, reset 0).
  - On mismatch the frame still completes through STOP; parity_err pulses in the same cycle data_valid would rise, and the byte is discarded.
- Not defined: no PARITY state, no parity ports; the frame is start + DATA_BITS + stop.

Test Plan:
- Reset, then div_load with div_in=4 (bit = 64 cycles); send 0xA5 with stop=1, data_ready=1 -> data_valid for 1 cycle, data_out=0xA5, frame_err=0, overrun=0.
- div_in=4; pulse rx_in low for 20 cycles only -> state returns to IDLE, busy falls, no data_valid.
- Send 0x3C with stop bit=0, line held low 200 cycles, then high -> frame_err single pulse, no data_valid, no retrigger until next falling edge.
- data_ready=0; send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once at the end of the second frame; data_ready=1 -> data_valid clears.
- div_load div_in=8 mid-frame while receiving at div 4 -> current byte decodes correctly at div 4; next frame decodes correctly at div 8. div_in=1 -> div_reg=2.
- Assert rst at bit 4 of a frame, release, send 0x5A -> all outputs at reset values during rst; data_out=0x5A afterward.
